// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite write arbiter: FSM states, BRESP codes
// and the AWPROT width.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2
    } state_t;

    localparam logic [1:0]  BRESP_OKAY   = 2'b00;
    localparam logic [1:0]  BRESP_SLVERR = 2'b10;
    localparam int unsigned PROT_W       = 3;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker: a lone requester always wins; when both request,
// the one not granted last wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/axi_lite_write_arbiter.sv
// Arbitrates two write requesters onto one AXI4-Lite write channel, one
// transaction at a time, with a bounded wait for the write response.
module axi_lite_write_arbiter
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [1:0]              req,
    input  logic [2*ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]     req_data,
    input  logic [2*(DATA_W/8)-1:0] req_strb,
    input  logic [2*PROT_W-1:0]     req_prot,
    output logic [1:0]              gnt,
    output logic [1:0]              done,
    output logic [1:0]              resp,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [ADDR_W-1:0]       AWADDR,
    output logic [PROT_W-1:0]       AWPROT,
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic [DATA_W-1:0]       WDATA,
    output logic [DATA_W/8-1:0]     WSTRB,
    input  logic                    BVALID,
    output logic                    BREADY,
    input  logic [1:0]              BRESP
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              state_q,   state_d;
    logic [1:0]          gnt_q,     gnt_d;
    logic [1:0]          done_q,    done_d;
    logic [1:0]          resp_q,    resp_d;
    logic                last_q,    last_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q,  wvalid_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q,  w_done_d;
    logic                bready_q,  bready_d;
    logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
    logic [PROT_W-1:0]   awprot_q,  awprot_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]   wstrb_q,   wstrb_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;

    logic [1:0]          pick;
    logic                aw_fin;
    logic                w_fin;

    rr_arbiter_2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (pick)
    );

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            resp_q    <= BRESP_OKAY;
            last_q    <= 1'b1;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            awprot_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            last_q    <= last_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            awprot_q  <= awprot_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
        end
    end

    // A channel counts as finished once its handshake was seen earlier or is
    // being seen on this edge; both must finish before waiting for BVALID.
    assign aw_fin = aw_done_q | (awvalid_q & AWREADY);
    assign w_fin  = w_done_q  | (wvalid_q  & WREADY);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        resp_d    = resp_q;
        last_d    = last_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        awprot_d  = awprot_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d     = pick;
                    awaddr_d  = pick[1] ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
                    wdata_d   = pick[1] ? req_data[2*DATA_W-1:DATA_W]   : req_data[DATA_W-1:0];
                    wstrb_d   = pick[1] ? req_strb[2*STRB_W-1:STRB_W]   : req_strb[STRB_W-1:0];
                    awprot_d  = pick[1] ? req_prot[2*PROT_W-1:PROT_W]   : req_prot[PROT_W-1:0];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ADDR_DATA;
                end
            end

            ADDR_DATA: begin
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else if (!awvalid_q && !aw_done_q) begin
                    awvalid_d = 1'b1;
                end
                if (wvalid_q && WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else if (!wvalid_q && !w_done_q) begin
                    wvalid_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = RESP;
                end
            end

            RESP: begin
                if ((BVALID && bready_q) || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    bready_d = 1'b0;
                    done_d   = gnt_q;
                    resp_d   = BVALID ? BRESP : BRESP_SLVERR;
                    last_d   = gnt_q[1];
                    gnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign resp    = resp_q;
    assign AWVALID = awvalid_q;
    assign AWADDR  = awaddr_q;
    assign AWPROT  = awprot_q;
    assign WVALID  = wvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign BREADY  = bready_q;

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Self-checking bench: a configurable slave and a transaction-level model of
// grant order, payload, handshake timing and completion latency.
module tb_axi_lite_write_arbiter;

    localparam int TO = 16;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic [1:0]  req = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic [7:0]  req_strb = '0;
    logic [5:0]  req_prot = '0;
    logic [1:0]  gnt, done, resp;
    logic        AWVALID, WVALID, BREADY;
    logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
    logic [31:0] AWADDR, WDATA;
    logic [2:0]  AWPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP = '0;

    int          cfg_aw = 0, cfg_w = 0, cfg_b = 0;
    logic        cfg_bf = 1'b0;
    logic [1:0]  cfg_bresp = '0;
    int          total = 0, bad = 0;
    int          m_last = 1;

    axi_lite_write_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .req(req), .req_addr(req_addr),
        .req_data(req_data), .req_strb(req_strb), .req_prot(req_prot),
        .gnt(gnt), .done(done), .resp(resp),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    always #5 ACLK = ~ACLK;

    // Slave: READY rises once VALID has been high for more than cfg_* cycles.
    initial begin : slave
        int s_aw, s_w, s_b;
        s_aw = 0; s_w = 0; s_b = 0;
        forever begin
            @(posedge ACLK);
            #1;
            s_aw = AWVALID ? s_aw + 1 : 0;
            s_w  = WVALID  ? s_w + 1  : 0;
            s_b  = BREADY  ? s_b + 1  : 0;
            AWREADY = AWVALID && (s_aw > cfg_aw);
            WREADY  = WVALID  && (s_w  > cfg_w);
            BVALID  = cfg_bf || (BREADY && (s_b > cfg_b));
            BRESP   = cfg_bresp;
        end
    end

    task automatic apply_reset();
        @(negedge ACLK);
        ARESETn = 1'b1;
        req = '0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b0;
        m_last = 1;
    endtask

    task automatic run_round(input logic [1:0] pat, input int aw_d, input int w_d,
                             input int b_d, input logic b_frc, input logic [1:0] bresp_v,
                             input logic drop_early, input logic [31:0] a0, input logic [31:0] d0,
                             input string name);
        logic [31:0] a1, d1, ea, ed;
        logic [3:0]  s0, s1, es;
        logic [2:0]  p0, p1, ep;
        logic [1:0]  exp_g, exp_resp, exp_gn;
        logic        exp_av, exp_wv, exp_br, seen;
        int          win, mx, bl, done_k, aw_n, w_n;
        a1 = $urandom; d1 = $urandom;
        s0 = 4'($urandom); s1 = 4'($urandom);
        p0 = 3'($urandom); p1 = 3'($urandom);
        @(negedge ACLK);
        cfg_aw = aw_d; cfg_w = w_d; cfg_b = b_d; cfg_bf = b_frc; cfg_bresp = bresp_v;
        req_addr = {a1, a0}; req_data = {d1, d0};
        req_strb = {s1, s0}; req_prot = {p1, p0};
        req = pat;
        if (pat == 2'b11) win = (m_last == 1) ? 0 : 1;
        else              win = pat[1] ? 1 : 0;
        exp_g = (win == 1) ? 2'b10 : 2'b01;
        ea = (win == 1) ? a1 : a0; ed = (win == 1) ? d1 : d0;
        es = (win == 1) ? s1 : s0; ep = (win == 1) ? p1 : p0;
        mx = (aw_d > w_d) ? aw_d : w_d;
        bl = b_frc ? 1 : 1 + b_d;
        done_k = 2 + mx + ((bl <= TO) ? bl : TO);
        exp_resp = (bl <= TO) ? bresp_v : 2'b10;
        aw_n = 0; w_n = 0; seen = 1'b0;
        for (int k = 0; k <= done_k + 20 && !seen; k++) begin
            @(negedge ACLK);
            exp_av = (k >= 1) && (k <= 1 + aw_d);
            exp_wv = (k >= 1) && (k <= 1 + w_d);
            exp_br = (k >= 2 + mx) && (k < done_k);
            exp_gn = (k < done_k) ? exp_g : 2'b00;
            total++;
            if (AWVALID !== exp_av || WVALID !== exp_wv || BREADY !== exp_br || gnt !== exp_gn) begin
                bad++;
                $display("FAIL %s_ctl k=%0d: got av=%b wv=%b br=%b gnt=%b want av=%b wv=%b br=%b gnt=%b",
                         name, k, AWVALID, WVALID, BREADY, gnt, exp_av, exp_wv, exp_br, exp_gn);
            end
            if (AWVALID) begin
                aw_n++;
                total++;
                if (AWADDR !== ea || AWPROT !== ep) begin
                    bad++;
                    $display("FAIL %s_aw: got addr=%h prot=%h want addr=%h prot=%h", name, AWADDR, AWPROT, ea, ep);
                end
            end
            if (WVALID) begin
                w_n++;
                total++;
                if (WDATA !== ed || WSTRB !== es) begin
                    bad++;
                    $display("FAIL %s_w: got data=%h strb=%h want data=%h strb=%h", name, WDATA, WSTRB, ed, es);
                end
            end
            if (drop_early && k == 1) begin
                req[win] = 1'b0;
                req_addr = {$urandom, $urandom};
                req_data = {$urandom, $urandom};
            end
            if (done !== 2'b00) begin
                seen = 1'b1;
                total++;
                if (done !== exp_g || k != done_k || resp !== exp_resp) begin
                    bad++;
                    $display("FAIL %s_done: got done=%b k=%0d resp=%b want done=%b k=%0d resp=%b",
                             name, done, k, resp, exp_g, done_k, exp_resp);
                end
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done want done=%b", name, exp_g);
        end
        total++;
        if (aw_n != aw_d + 1 || w_n != w_d + 1) begin
            bad++;
            $display("FAIL %s_vcnt: got aw=%0d w=%0d want aw=%0d w=%0d", name, aw_n, w_n, aw_d + 1, w_d + 1);
        end
        req = '0;
        m_last = win;
        @(negedge ACLK);
        total++;
        if (done !== 2'b00 || gnt !== 2'b00) begin
            bad++;
            $display("FAIL %s_after: got done=%b gnt=%b want 00 00", name, done, gnt);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({AWVALID, WVALID, BREADY, gnt, done, resp, AWADDR, WDATA, WSTRB, AWPROT} !== '0) begin
            bad++;
            $display("FAIL %s: got av=%b wv=%b br=%b gnt=%b done=%b resp=%b addr=%h data=%h strb=%h prot=%h want all 0",
                     name, AWVALID, WVALID, BREADY, gnt, done, resp, AWADDR, WDATA, WSTRB, AWPROT);
        end
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check_all_zero("reset_hold");
        ARESETn = 1'b0;
        m_last = 1;
        @(negedge ACLK);
        check_all_zero("reset_release");
    endtask

    task automatic test_single();
        run_round(2'b01, 0, 0, 0, 1'b0, 2'b00, 1'b0, 32'h10, 32'hA5A5A5A5, "single");
        run_round(2'b10, 0, 0, 0, 1'b0, 2'b11, 1'b0, $urandom, $urandom, "single1");
    endtask

    task automatic test_round_robin();
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  order [4];
        int          n, w;
        apply_reset();
        a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_bf = 1'b0; cfg_bresp = 2'b00;
        req_addr = {a1, a0}; req_data = {d1, d0};
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
        req = 2'b11;
        n = 0;
        for (int c = 0; c < 120 && n < 4; c++) begin
            @(negedge ACLK);
            w = order[n][1] ? 1 : 0;
            if (AWVALID && AWREADY) begin
                total++;
                if (AWADDR !== ((w == 1) ? a1 : a0)) begin
                    bad++;
                    $display("FAIL rr_addr%0d: got %h want %h", n, AWADDR, (w == 1) ? a1 : a0);
                end
            end
            if (WVALID && WREADY) begin
                total++;
                if (WDATA !== ((w == 1) ? d1 : d0)) begin
                    bad++;
                    $display("FAIL rr_data%0d: got %h want %h", n, WDATA, (w == 1) ? d1 : d0);
                end
            end
            if (done !== 2'b00) begin
                total++;
                if (done !== order[n]) begin
                    bad++;
                    $display("FAIL rr_order%0d: got %b want %b", n, done, order[n]);
                end
                m_last = w;
                n++;
            end
        end
        req = '0;
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL rr_count: got %0d want 4", n);
        end
        @(negedge ACLK);
    endtask

    task automatic test_handshake_delay();
        run_round(2'b01, 3, 0, 0, 1'b0, 2'b00, 1'b0, $urandom, $urandom, "aw_delay");
        run_round(2'b10, 0, 2, 1, 1'b0, 2'b01, 1'b0, $urandom, $urandom, "w_delay");
        run_round(2'b11, 2, 2, 0, 1'b0, 2'b00, 1'b0, $urandom, $urandom, "both_delay");
    endtask

    task automatic test_timeout();
        run_round(2'b01, 0, 0, 1000, 1'b0, 2'b00, 1'b0, $urandom, $urandom, "timeout");
        run_round(2'b10, 1, 0, TO - 1, 1'b0, 2'b01, 1'b0, $urandom, $urandom, "to_edge_ok");
        run_round(2'b01, 0, 1, TO, 1'b0, 2'b01, 1'b0, $urandom, $urandom, "to_edge_err");
    endtask

    task automatic test_bvalid_ignored();
        run_round(2'b10, 2, 1, 0, 1'b1, 2'b01, 1'b0, $urandom, $urandom, "bvalid_early");
        run_round(2'b11, 0, 0, 3, 1'b0, 2'b00, 1'b1, $urandom, $urandom, "drop_req");
    endtask

    task automatic test_reset_mid();
        int dn;
        @(negedge ACLK);
        cfg_aw = 5; cfg_w = 5; cfg_b = 0; cfg_bf = 1'b0; cfg_bresp = 2'b00;
        req_addr = {$urandom, $urandom}; req_data = {$urandom, $urandom};
        req = 2'b10;
        repeat (2) @(negedge ACLK);
        total++;
        if (AWVALID !== 1'b1 || gnt !== 2'b10) begin
            bad++;
            $display("FAIL rmid_pre: got av=%b gnt=%b want 1 10", AWVALID, gnt);
        end
        #1 ARESETn = 1'b1;
        #1 check_all_zero("rmid_async");
        req = '0;
        dn = 0;
        repeat (3) begin
            @(negedge ACLK);
            if (done !== 2'b00) dn++;
        end
        ARESETn = 1'b0;
        m_last = 1;
        repeat (3) begin
            @(negedge ACLK);
            if (done !== 2'b00) dn++;
        end
        total++;
        if (dn != 0) begin
            bad++;
            $display("FAIL rmid_nodone: got %0d pulses want 0", dn);
        end
        run_round(2'b11, 0, 0, 0, 1'b0, 2'b00, 1'b0, $urandom, $urandom, "rmid_next");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_round(2'($urandom_range(1, 3)), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 20), ($urandom_range(0, 5) == 0), 2'($urandom),
                      ($urandom_range(0, 3) == 0), $urandom, $urandom, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_handshake_delay();
        test_timeout();
        test_bvalid_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/axi_lite_write_arbiter.md
AXI_LITE_WRITE_ARBITER -- requirements
Module: axi_lite_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 32, write address width.
  DATA_W, 32, write data width; WSTRB width is DATA_W/8.
  TIMEOUT, 16, maximum cycles to wait for BVALID before a forced error completion.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  ACLK  in  1  single clock; all logic on the rising edge.
  ARESETn  in  1  reset, asynchronous, active-high.
  req  in  2  per-requester write request, held until its done pulse.
  req_addr  in  2*ADDR_W  per-requester address; requester i uses slice i.
  req_data  in  2*DATA_W  per-requester write data.
  req_strb  in  2*DATA_W/8  per-requester byte strobes.
  req_prot  in  6  per-requester AWPROT, 3 bits each.
  gnt  out  2  one-hot grant, held for the whole transaction.
  done  out  2  one-cycle completion pulse for the granted requester.
  resp  out  2  BRESP of the last completion, valid while done is high.
  AWVALID / AWREADY  out / in  1 each  AXI4-Lite write-address handshake.
  AWADDR  out  ADDR_W  write address.
  AWPROT  out  3  protection bits.
  WVALID / WREADY  out / in  1 each  write-data handshake.
  WDATA  out  DATA_W  write data.
  WSTRB  out  DATA_W/8  byte strobes.
  BVALID / BREADY  in / out  1 each  write-response handshake.
  BRESP  in  2  write response.

Function
REQ-003 FSM states SHALL be IDLE, ADDR_DATA and RESP.
REQ-004 IDLE: when any req bit is high at an edge, the block SHALL set gnt one-hot, latch that requester's addr/data/strb/prot, and enter ADDR_DATA.
REQ-005 Arbitration SHALL be round-robin: with both requesting, grant goes to the requester not granted last; with one requesting, that one wins.
REQ-006 On entry to ADDR_DATA, AWVALID and WVALID SHALL both go high in the same cycle, driven from latched registers only.
REQ-007 Each VALID SHALL stay high and its payload stable until the cycle its READY is sampled high, then drop the next cycle; the AW and W handshakes complete independently, in either order or together.
REQ-008 When both handshakes are complete, the block SHALL enter RESP with BREADY high.
REQ-009 RESP: on BVALID&BREADY the block SHALL drop BREADY, pulse done[g] for one cycle with resp=BRESP, clear gnt, update the last-grant pointer and return to IDLE.
REQ-010 Minimum latency SHALL be: req sampled at edge N, VALIDs high after edge N+1, done high after edge N+3 when AWREADY, WREADY and BVALID are all already high.
REQ-011 In RESP a counter SHALL count cycles; if it reaches TIMEOUT without BVALID, the block SHALL complete as in REQ-009 with resp=2'b10 (SLVERR).
REQ-012 Deassertion of req by the granted requester mid-transaction SHALL be ignored; the transaction runs to completion.
REQ-013 The block SHALL return to IDLE for at least one cycle between transactions; back-to-back requests from the same requester are not granted twice in a row while the other requests.
REQ-014 BVALID in IDLE or ADDR_DATA SHALL be ignored, and BREADY SHALL stay low in those states.

Reset
REQ-015 While ARESETn is high, asynchronously: state=IDLE, AWVALID=WVALID=BREADY=0, gnt=done=0, resp=0, AWADDR/WDATA/WSTRB/AWPROT=0, timeout counter=0, last-grant pointer=1, so that the first contested grant goes to requester 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction with no done pulse.

Structure
REQ-017 The shared package axi_lite_pkg SHALL hold the state enumeration, the BRESP codes (OKAY=2'b00, SLVERR=2'b10) and the PROT width constant.
REQ-018 The two-way round-robin picker SHALL be the sub-module rr_arbiter_2, with inputs req[1:0] and last and output one-hot gnt.

Verification
REQ-019 Only req=2'b01, addr0=0x10, data0=0xA5A5A5A5, slave always ready, BRESP=0 -> AWADDR=0x10 and WDATA=0xA5A5A5A5 for one cycle; done=2'b01 and resp=0 exactly 3 cycles after the req edge.
REQ-020 req=2'b11 held high after reset -> grants in order 01, 10, 01, 10, each with the correct addr/data slice.
REQ-021 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held with stable AWADDR for 4 cycles, then RESP is entered.
REQ-022 BVALID never asserted, TIMEOUT=16 -> done pulses exactly 16 cycles after RESP entry with resp=2'b10.
REQ-023 ARESETn pulsed while in ADDR_DATA -> all outputs 0 in the same cycle, no done pulse, and the next contested grant goes to requester 0.
